// File: rtl/lcd_timing_gen.sv
// RGB LCD timing generator with porch/polarity parameters, a one-cycle-ahead
// pixel request port for an external frame source and per-frame test patterns.
module lcd_timing_gen #(
    parameter int unsigned H_SYNC   = 1,
    parameter int unsigned H_BACK   = 46,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FRONT  = 210,
    parameter int unsigned V_SYNC   = 1,
    parameter int unsigned V_BACK   = 23,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 22,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned GRID     = 32,
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT,
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT,
    localparam int unsigned X_W     = $clog2(H_ACTIVE),
    localparam int unsigned Y_W     = $clog2(V_ACTIVE)
) (
    input  logic           pixel_clk,
    input  logic           rst_n,
    input  logic           display_en,
    input  logic [1:0]     mode,
    input  logic [23:0]    solid_color,
    input  logic [23:0]    pixel_data,
    output logic           data_req,
    output logic [X_W-1:0] pixel_x,
    output logic [Y_W-1:0] pixel_y,
    output logic           frame_start,
    output logic           hs,
    output logic           vs,
    output logic           de,
    output logic [23:0]    rgb
);

    localparam int unsigned HC_W      = $clog2(H_TOTAL);
    localparam int unsigned VC_W      = $clog2(V_TOTAL);
    localparam int unsigned H_ACT_BEG = H_SYNC + H_BACK;
    localparam int unsigned H_ACT_END = H_SYNC + H_BACK + H_ACTIVE;
    localparam int unsigned V_ACT_BEG = V_SYNC + V_BACK;
    localparam int unsigned V_ACT_END = V_SYNC + V_BACK + V_ACTIVE;
    localparam int unsigned BAR_W     = H_ACTIVE / 8;

    logic [HC_W-1:0] r_h_cnt;
    logic [VC_W-1:0] r_v_cnt;
    logic [1:0]      r_mode;
    logic [23:0]     r_solid;

    logic            r_req;
    logic [X_W-1:0]  r_px;
    logic [Y_W-1:0]  r_py;
    logic            r_hsync1;
    logic            r_vsync1;
    logic            r_fs1;

    logic            w_h_sync;
    logic            w_v_sync;
    logic            w_h_act;
    logic            w_v_act;
    logic            w_act;
    logic            w_frame0;
    logic [2:0]      w_bar;
    logic            w_grid;
    logic [23:0]     w_rgb;

    // Stage 0: line and frame position counters
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!display_en) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == HC_W'(H_TOTAL - 1)) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == VC_W'(V_TOTAL - 1)) ? '0 : r_v_cnt + VC_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HC_W'(1);
        end
    end

    assign w_h_sync = (r_h_cnt < HC_W'(H_SYNC));
    assign w_v_sync = (r_v_cnt < VC_W'(V_SYNC));
    assign w_h_act  = (r_h_cnt >= HC_W'(H_ACT_BEG)) && (r_h_cnt < HC_W'(H_ACT_END));
    assign w_v_act  = (r_v_cnt >= VC_W'(V_ACT_BEG)) && (r_v_cnt < VC_W'(V_ACT_END));
    assign w_act    = w_h_act && w_v_act;
    assign w_frame0 = (r_h_cnt == '0) && (r_v_cnt == '0);

    // Pattern selection is frozen at the top of each frame
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= '0;
            r_solid <= '0;
        end else if (display_en && w_frame0) begin
            r_mode  <= mode;
            r_solid <= solid_color;
        end
    end

    // Stage 1: request and coordinates for the external source
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req    <= 1'b0;
            r_px     <= '0;
            r_py     <= '0;
            r_hsync1 <= 1'b0;
            r_vsync1 <= 1'b0;
            r_fs1    <= 1'b0;
        end else if (!display_en) begin
            r_req    <= 1'b0;
            r_px     <= '0;
            r_py     <= '0;
            r_hsync1 <= 1'b0;
            r_vsync1 <= 1'b0;
            r_fs1    <= 1'b0;
        end else begin
            r_req    <= w_act;
            r_px     <= w_act ? X_W'(r_h_cnt - HC_W'(H_ACT_BEG)) : '0;
            r_py     <= w_act ? Y_W'(r_v_cnt - VC_W'(V_ACT_BEG)) : '0;
            r_hsync1 <= w_h_sync;
            r_vsync1 <= w_v_sync;
            r_fs1    <= w_frame0;
        end
    end

    assign data_req = r_req;
    assign pixel_x  = r_px;
    assign pixel_y  = r_py;

    // Bar index by constant thresholds; leftover pixels fall into bar 7
    always_comb begin
        w_bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (r_px >= X_W'(k * BAR_W)) w_bar = 3'(k);
        end
    end

    assign w_grid = ((r_px & X_W'(GRID - 1)) == '0) || ((r_py & Y_W'(GRID - 1)) == '0);

    always_comb begin
        w_rgb = '0;
        case (r_mode)
            2'd0: w_rgb = pixel_data;
            2'd1: begin
                case (w_bar)
                    3'd0:    w_rgb = 24'hFFFFFF;
                    3'd1:    w_rgb = 24'hFFFF00;
                    3'd2:    w_rgb = 24'h00FFFF;
                    3'd3:    w_rgb = 24'h00FF00;
                    3'd4:    w_rgb = 24'hFF00FF;
                    3'd5:    w_rgb = 24'hFF0000;
                    3'd6:    w_rgb = 24'h0000FF;
                    default: w_rgb = 24'h000000;
                endcase
            end
            2'd2:    w_rgb = w_grid ? 24'hFFFFFF : 24'h000000;
            default: w_rgb = r_solid;
        endcase
    end

    // Stage 2: panel pins
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else if (!display_en) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            hs          <= r_hsync1 ? HS_POL : ~HS_POL;
            vs          <= r_vsync1 ? VS_POL : ~VS_POL;
            de          <= r_req;
            rgb         <= r_req ? w_rgb : '0;
            frame_start <= r_fs1;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: two instances (full-width lines / tiny panel)
// compared every cycle against an arithmetic timing and pattern model.
module tb_lcd_timing_gen;

    typedef struct {
        int hsw, hb, ha, hf;
        int vsw, vb, va, vf;
        int grid, xw;
        bit hp, vp;
    } tim_t;

    localparam int A_X_W = 10;
    localparam int A_Y_W = 3;
    localparam int B_X_W = 4;
    localparam int B_Y_W = 3;
    localparam longint FT_A = 1057 * 13;
    localparam longint FT_B = 25 * 13;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] solid;
    logic [23:0] pd_a, pd_b;

    logic             a_req, a_fs, a_hs, a_vs, a_de;
    logic [A_X_W-1:0] a_x;
    logic [A_Y_W-1:0] a_y;
    logic [23:0]      a_rgb;
    logic             b_req, b_fs, b_hs, b_vs, b_de;
    logic [B_X_W-1:0] b_x;
    logic [B_Y_W-1:0] b_y;
    logic [23:0]      b_rgb;

    int          n_tests = 0;
    int          n_fail  = 0;
    longint      cyc     = 0;
    int          lm_a = 0, lm_b = 0;
    logic [23:0] ls_a = '0, ls_b = '0;
    bit          mon_on = 1'b0;
    tim_t        ta, tb;

    lcd_timing_gen #(
        .V_SYNC(1), .V_BACK(2), .V_ACTIVE(8), .V_FRONT(2)
    ) dut_a (
        .pixel_clk(clk), .rst_n(rst_n), .display_en(en), .mode(mode),
        .solid_color(solid), .pixel_data(pd_a), .data_req(a_req),
        .pixel_x(a_x), .pixel_y(a_y), .frame_start(a_fs), .hs(a_hs),
        .vs(a_vs), .de(a_de), .rgb(a_rgb)
    );

    lcd_timing_gen #(
        .H_SYNC(2), .H_BACK(3), .H_ACTIVE(16), .H_FRONT(4),
        .V_SYNC(1), .V_BACK(2), .V_ACTIVE(8), .V_FRONT(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .GRID(4)
    ) dut_b (
        .pixel_clk(clk), .rst_n(rst_n), .display_en(en), .mode(mode),
        .solid_color(solid), .pixel_data(pd_b), .data_req(b_req),
        .pixel_x(b_x), .pixel_y(b_y), .frame_start(b_fs), .hs(b_hs),
        .vs(b_vs), .de(b_de), .rgb(b_rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, want);
        end
    endtask

    function automatic logic [23:0] bar_rgb(input int b);
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected outputs after k enabled edges, from the position index alone
    function automatic void model(input tim_t t, input longint k, input int lm,
                                  input logic [23:0] ls, output logic [4:0] ctl,
                                  output logic [23:0] rgb, output int px, output int py);
        longint ht = longint'(t.hsw + t.hb + t.ha + t.hf);
        longint vt = longint'(t.vsw + t.vb + t.va + t.vf);
        longint n1 = k - 1;
        longint n2 = k - 2;
        int h, v, x, y, b;
        ctl = {1'b0, ~t.hp, ~t.vp, 1'b0, 1'b0};
        rgb = '0;
        px  = 0;
        py  = 0;
        if (n1 >= 0) begin
            h = int'(n1 % ht);
            v = int'((n1 / ht) % vt);
            if (h >= t.hsw + t.hb && h < t.hsw + t.hb + t.ha &&
                v >= t.vsw + t.vb && v < t.vsw + t.vb + t.va) begin
                ctl[0] = 1'b1;
                px = h - (t.hsw + t.hb);
                py = v - (t.vsw + t.vb);
            end
        end
        if (n2 >= 0) begin
            h = int'(n2 % ht);
            v = int'((n2 / ht) % vt);
            ctl[4] = ((n2 % (ht * vt)) == 0);
            ctl[3] = (h < t.hsw) ? t.hp : ~t.hp;
            ctl[2] = (v < t.vsw) ? t.vp : ~t.vp;
            if (h >= t.hsw + t.hb && h < t.hsw + t.hb + t.ha &&
                v >= t.vsw + t.vb && v < t.vsw + t.vb + t.va) begin
                ctl[1] = 1'b1;
                x = h - (t.hsw + t.hb);
                y = v - (t.vsw + t.vb);
                case (lm)
                    0: rgb = 24'((y << t.xw) | x);
                    1: begin
                        b = x / (t.ha / 8);
                        if (b > 7) b = 7;
                        rgb = bar_rgb(b);
                    end
                    2: rgb = ((x % t.grid) == 0 || (y % t.grid) == 0) ? 24'hFFFFFF : 24'h000000;
                    default: rgb = ls;
                endcase
            end
        end
    endfunction

    // Count enabled edges and capture the mode each instance freezes per frame
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !en) begin
            cyc = 0;
        end else begin
            if ((cyc % FT_A) == 0) begin lm_a = int'(mode); ls_a = solid; end
            if ((cyc % FT_B) == 0) begin lm_b = int'(mode); ls_b = solid; end
            cyc++;
        end
    end

    // Per-cycle scoreboard, then the external source answers this cycle's request
    always @(negedge clk) begin
        logic [4:0]  ctl;
        logic [23:0] rgb;
        int          px, py;
        if (mon_on) begin
            model(ta, cyc, lm_a, ls_a, ctl, rgb, px, py);
            check("A_ctl", 64'({a_fs, a_hs, a_vs, a_de, a_req}), 64'(ctl));
            check("A_xy", 64'({a_y, a_x}), 64'((py << A_X_W) | px));
            check("A_rgb", 64'(a_rgb), 64'(rgb));
            model(tb, cyc, lm_b, ls_b, ctl, rgb, px, py);
            check("B_ctl", 64'({b_fs, b_hs, b_vs, b_de, b_req}), 64'(ctl));
            check("B_xy", 64'({b_y, b_x}), 64'((py << B_X_W) | px));
            check("B_rgb", 64'(b_rgb), 64'(rgb));
        end
        pd_a = a_req ? 24'({a_y, a_x}) : 24'($urandom);
        pd_b = b_req ? 24'({b_y, b_x}) : 24'($urandom);
    end

    task automatic check_idle(input string tag);
        check({tag, "_A"}, 64'({a_fs, a_hs, a_vs, a_de, a_req, a_x, a_y, a_rgb}),
              64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A_X_W'(0), A_Y_W'(0), 24'h0}));
        check({tag, "_B"}, 64'({b_fs, b_hs, b_vs, b_de, b_req, b_x, b_y, b_rgb}),
              64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, B_X_W'(0), B_Y_W'(0), 24'h0}));
    endtask

    task automatic start_and_check_fs();
        en = 1'b1;
        @(negedge clk);
        check("fs_edge1", 64'({a_fs, b_fs}), 64'(2'b00));
        @(negedge clk);
        check("fs_edge2", 64'({a_fs, b_fs}), 64'(2'b11));
    endtask

    initial begin
        ta = '{hsw: 1, hb: 46, ha: 800, hf: 210, vsw: 1, vb: 2, va: 8, vf: 2,
               grid: 32, xw: A_X_W, hp: 1'b0, vp: 1'b0};
        tb = '{hsw: 2, hb: 3, ha: 16, hf: 4, vsw: 1, vb: 2, va: 8, vf: 2,
               grid: 4, xw: B_X_W, hp: 1'b1, vp: 1'b1};
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd3;
        solid = 24'h123456;
        pd_a  = '0;
        pd_b  = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        mon_on = 1'b1;
        repeat (4) @(negedge clk);
        check_idle("en_low");
        start_and_check_fs();

        for (int s = 0; s < 8; s++) begin
            case (s % 4)
                0: mode = 2'd3;
                1: mode = 2'd1;
                2: mode = 2'd2;
                default: mode = 2'd0;
            endcase
            solid = (s == 0) ? 24'h123456 : 24'($urandom);
            repeat ($urandom_range(5000, 9000)) @(negedge clk);
            if (s == 2) begin
                en = 1'b0;
                repeat (4) @(negedge clk);
                check_idle("en_drop");
                start_and_check_fs();
            end
            if (s == 4) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                en    = 1'b0;
                #1;
                check_idle("async_rst");
                repeat (5) @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(negedge clk);
                check_idle("post_rst");
                start_and_check_fs();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
